wb_merge: RTL



---
 rtl/wb_merge.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/wb_merge.sv
// Writeback merge stage: owns the single register-file write port and merges
// the fixed-latency primary writeback with buffered long-latency secondary
// results. Exports per-register busy flags for decode hazard checks.
// Optional feature macro: WB_MERGE_BYPASS_EN (adds forwarding from the output
// register and drops that term from the busy flags).

package brisc_pkg;
    parameter int XLEN = 32;
endpackage

module wb_merge #(
    parameter int  XLEN      = brisc_pkg::XLEN,
    parameter int  REG_NUM   = 32,
    parameter int  DEPTH     = 4,
    localparam int REG_WIDTH = $clog2(REG_NUM),
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pri_valid,
    input  logic [REG_WIDTH-1:0] pri_rd,
    input  logic [XLEN-1:0]      pri_data,
    input  logic                 sec_valid,
    output logic                 sec_ready,
    input  logic [REG_WIDTH-1:0] sec_rd,
    input  logic [XLEN-1:0]      sec_data,
    output logic                 rf_enable,
    output logic [REG_WIDTH-1:0] rf_rd_addr,
    output logic [XLEN-1:0]      rf_write_data,
    input  logic [REG_WIDTH-1:0] rs1_addr,
    input  logic [REG_WIDTH-1:0] rs2_addr,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
`ifdef WB_MERGE_BYPASS_EN
    output logic                 rs1_fwd_valid,
    output logic                 rs2_fwd_valid,
    output logic [XLEN-1:0]      rs1_fwd_data,
    output logic [XLEN-1:0]      rs2_fwd_data,
`endif
    output logic [CW-1:0]        fifo_count
);

    logic [DEPTH-1:0]                ent_vld_q, ent_vld_d;
    logic [DEPTH-1:0]                ent_sq_q,  ent_sq_d;
    logic [DEPTH-1:0][REG_WIDTH-1:0] ent_rd_q,  ent_rd_d;
    logic [DEPTH-1:0][XLEN-1:0]      ent_data_q, ent_data_d;
    logic [PW-1:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                   count_q, count_d;
    logic                            rf_en_q, rf_en_d;
    logic [REG_WIDTH-1:0]            rf_addr_q, rf_addr_d;
    logic [XLEN-1:0]                 rf_data_q, rf_data_d;
    logic                            full, push, pop;
    logic                            fifo_hit1, fifo_hit2;

    // Full is judged on registered occupancy only, so a same-cycle pop never frees a slot
    assign full       = (count_q == CW'(DEPTH));
    assign sec_ready  = !full;
    assign push       = sec_valid && !full;
    assign pop        = !pri_valid && (count_q != '0);
    assign fifo_count = count_q;

    assign rf_enable     = rf_en_q;
    assign rf_rd_addr    = rf_addr_q;
    assign rf_write_data = rf_data_q;

    // Next-state: port selection (primary first), WAW squash, FIFO push/pop
    always_comb begin
        ent_vld_d  = ent_vld_q;
        ent_sq_d   = ent_sq_q;
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rf_en_d    = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;

        if (pri_valid) begin
            rf_en_d   = (pri_rd != '0);
            rf_addr_d = pri_rd;
            rf_data_d = pri_data;
            // Older buffered writes to the same register are now stale
            if (pri_rd != '0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_vld_q[i] && ent_rd_q[i] == pri_rd) ent_sq_d[i] = 1'b1;
                end
            end
        end else if (pop) begin
            rf_en_d             = (ent_rd_q[rd_ptr_q] != '0) && !ent_sq_q[rd_ptr_q];
            rf_addr_d           = ent_rd_q[rd_ptr_q];
            rf_data_d           = ent_data_q[rd_ptr_q];
            ent_vld_d[rd_ptr_q] = 1'b0;
            ent_sq_d[rd_ptr_q]  = 1'b0;
            rd_ptr_d            = rd_ptr_q + PW'(1);
        end

        // Pushed entry lands in an empty slot, so the squash above never touches it
        if (push) begin
            ent_vld_d[wr_ptr_q]  = 1'b1;
            ent_sq_d[wr_ptr_q]   = 1'b0;
            ent_rd_d[wr_ptr_q]   = sec_rd;
            ent_data_d[wr_ptr_q] = sec_data;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_vld_q  <= '0;
            ent_sq_q   <= '0;
            ent_rd_q   <= '0;
            ent_data_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_en_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            ent_vld_q  <= ent_vld_d;
            ent_sq_q   <= ent_sq_d;
            ent_rd_q   <= ent_rd_d;
            ent_data_q <= ent_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rf_en_q    <= rf_en_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
        end
    end

    // Busy lookup: any live (valid, non-squashed) buffered write to the source
    always_comb begin
        fifo_hit1 = 1'b0;
        fifo_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld_q[i] && !ent_sq_q[i] && ent_rd_q[i] == rs1_addr) fifo_hit1 = 1'b1;
            if (ent_vld_q[i] && !ent_sq_q[i] && ent_rd_q[i] == rs2_addr) fifo_hit2 = 1'b1;
        end
    end

`ifdef WB_MERGE_BYPASS_EN
    // Output-register write is forwarded instead of stalling decode
    assign rs1_fwd_valid = rf_en_q && rf_addr_q == rs1_addr && rs1_addr != '0;
    assign rs2_fwd_valid = rf_en_q && rf_addr_q == rs2_addr && rs2_addr != '0;
    assign rs1_fwd_data  = rf_data_q;
    assign rs2_fwd_data  = rf_data_q;
    assign rs1_busy      = (rs1_addr != '0) && fifo_hit1;
    assign rs2_busy      = (rs2_addr != '0) && fifo_hit2;
`else
    assign rs1_busy = (rs1_addr != '0) && (fifo_hit1 || (rf_en_q && rf_addr_q == rs1_addr));
    assign rs2_busy = (rs2_addr != '0) && (fifo_hit2 || (rf_en_q && rf_addr_q == rs2_addr));
`endif

endmodule
